// File: rtl/envelope_gen_if.sv
// Voice envelope bus: note gate and ADSR shape settings in, stepped level and phase out.
// No handshake: settings are sampled every clock, and level/state/active are valid every cycle.
interface envelope_gen_if;
    logic       gate;
    logic [3:0] attack_rate;
    logic [3:0] decay_rate;
    logic [3:0] sustain_level;
    logic [3:0] release_rate;
    logic [3:0] level;
    logic [2:0] state;
    logic       active;

    modport master (
        output gate, attack_rate, decay_rate, sustain_level, release_rate,
        input  level, state, active
    );

    modport slave (
        input  gate, attack_rate, decay_rate, sustain_level, release_rate,
        output level, state, active
    );
endinterface

// File: rtl/envelope_gen.sv
// Per-voice ADSR envelope: a gate plus four 4-bit shape settings become a registered 0..15 level.
// Level steps are paced by a free-running prescaler tick divided by a per-phase rate counter.
module envelope_gen #(
    parameter int PRESCALE_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    envelope_gen_if.slave env
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            level_q, level_d;
    logic [3:0]            rate_cnt_q;
    logic [3:0]            rate_sel;
    logic [PRESCALE_W-1:0] presc_q;
    logic                  gate_q;
    logic                  tick;
    logic                  step;
    logic                  rise;

    assign tick = &presc_q;
    assign rise = env.gate && !gate_q;
    assign step = tick && (rate_cnt_q == rate_sel);

    always_comb begin
        rate_sel = 4'd0;
        case (state_q)
            ATTACK:  rate_sel = env.attack_rate;
            DECAY:   rate_sel = env.decay_rate;
            RELEASE: rate_sel = env.release_rate;
            default: rate_sel = 4'd0;
        endcase
    end

    // Retrigger and gate-off keep the current level so the envelope never jumps.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (rise) begin
            state_d = ATTACK;
        end else if (!env.gate &&
                     (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else begin
            case (state_q)
                IDLE: level_d = 4'd0;
                ATTACK: begin
                    if (level_q == 4'd15) state_d = DECAY;
                    else if (step)        level_d = level_q + 4'd1;
                end
                DECAY: begin
                    if (level_q <= env.sustain_level) state_d = SUSTAIN;
                    else if (step)                    level_d = level_q - 4'd1;
                end
                SUSTAIN: level_d = env.sustain_level;
                RELEASE: begin
                    if (level_q == 4'd0) state_d = IDLE;
                    else if (step)       level_d = level_q - 4'd1;
                end
                default: begin
                    state_d = IDLE;
                    level_d = 4'd0;
                end
            endcase
        end
    end

    // The prescaler is never cleared by gate; only the rate counter restarts on a phase change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            rate_cnt_q <= 4'd0;
            gate_q     <= 1'b0;
            state_q    <= IDLE;
            level_q    <= 4'd0;
        end else begin
            presc_q <= presc_q + 1'b1;
            gate_q  <= env.gate;
            state_q <= state_d;
            level_q <= level_d;
            if (state_d != state_q)
                rate_cnt_q <= 4'd0;
            else if (step)
                rate_cnt_q <= 4'd0;
            else if (tick)
                rate_cnt_q <= rate_cnt_q + 4'd1;
        end
    end

    assign env.level  = level_q;
    assign env.state  = state_q;
    assign env.active = (state_q != IDLE);

endmodule

// File: doc/envelope_gen.md
# envelope_gen

Per-voice ADSR envelope generator producing the 4-bit amplitude level that drives the volume operand of the voice's 4x4 amplitude multiplier. The oscillator's 4-bit sample goes to the other multiplier operand, and the 8-bit product feeds the mixer. The block converts a note gate plus four 4-bit shape settings into a stepped 0–15 level. It uses a free-running prescaler and a per-phase rate counter.

## Interface
- PRESCALE_W, default 8: prescaler width; one base tick every 2^PRESCALE_W clocks.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- gate  in  1  note on (1) / off (0); synchronous to clk.
- attack_rate  in  4  attack step period select.
- decay_rate  in  4  decay step period select.
- sustain_level  in  4  sustain level, 0–15.
- release_rate  in  4  release step period select.
- level  out  4  envelope level, registered; goes to the multiplier volume operand.
- state  out  3  current phase: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; registered.
- active  out  1  high when state != IDLE; decoded from the state register.

## Operation
- Prescaler:
  - PRESCALE_W-bit free-running up-counter that wraps.
  - tick is high in the cycle the counter equals all-ones.
  - The prescaler is never cleared by gate.
- Rate counter (4-bit), using the rate input of the current phase:
  - tick && rate_cnt == rate: step is high and rate_cnt clears to 0.
  - tick && rate_cnt != rate: rate_cnt increments.
  - Step period is (rate+1)·2^PRESCALE_W clocks.
  - rate_cnt clears on every state change.
- Gate edge: gate_q is a registered copy of gate; rise = gate && !gate_q.
- Per-cycle priority, highest first:
  1. rise: state → ATTACK. level is kept (no jump to 0), so a retrigger continues from the current level.
  2. !gate in ATTACK, DECAY or SUSTAIN: state → RELEASE, level kept.
  3. Phase rules:
     - IDLE: level = 0.
     - ATTACK: if level == 15, go to DECAY; else on step, level += 1.
     - DECAY: if level <= sustain_level, go to SUSTAIN; else on step, level -= 1.
     - SUSTAIN: level <= sustain_level every cycle, so it tracks live changes in either direction.
     - RELEASE: if level == 0, go to IDLE; else on step, level -= 1.
- Arithmetic: level never wraps. Increments happen only below 15 and decrements only above 0 or above sustain_level.
- gate held high with no rising edge after release/IDLE causes no retrigger. A new rising edge is required.
- Rate or sustain_level changes mid-phase take effect on the next compare; no restart.

## Timing
- Reset (async assert, synchronous-to-clk release):
  - level = 0, state = IDLE, active = 0.
  - prescaler = 0, rate_cnt = 0, gate_q = 0.
  - Reset mid-operation aborts the envelope immediately, without waiting for a clock.
- After reset release, the first tick occurs at clock 2^PRESCALE_W − 1.
- Gate to state latency is 1 clock: rise sampled at edge N gives state = ATTACK after edge N.
- The first attack step lands 0 to (rate+1)·2^PRESCALE_W clocks after the rise. This jitter comes from the unaligned prescaler and is accepted.
- A phase-end condition (level == 15, level <= sustain, level == 0) changes state on the clock after the condition becomes true. That clock produces no level step.
- level and state are register outputs with no combinational path from inputs.
- The multiplier downstream is combinational, so the product follows level with 0 added cycles.

## Test plan
All scenarios use PRESCALE_W=2 (tick every 4 clocks).
- Reset: assert rst_n=0 mid-attack at level 7 → level=0, state=0, active=0 before the next clk edge; these hold until release.
- Attack: attack_rate=0, gate 0→1 from IDLE → state=1 one clock later, level +1 every 4 clocks, reaching 15 after 15 steps; state=2 one clock later.
- Decay and sustain tracking:
  - decay_rate=1, sustain_level=8 → level 15→8 at one step per 8 clocks, then state=3, level=8.
  - Change sustain_level to 5 → level=5 the next clock.
  - Change sustain_level to 12 → level=12 the next clock.
- Release: gate→0 in SUSTAIN at level 5, release_rate=0 → state=4 next clock, level −1 every 4 clocks to 0; then state=0, active=0.
- Retrigger: gate→0, release runs to level 3, then gate→1 → state=1 with level=3 (no drop to 0), climbing 3→15.
- Priorities and edges:
  - sustain_level=15: attack reaches 15 → DECAY for exactly 1 clock → SUSTAIN at 15.
  - gate falls in the same clock attack hits 15 → state=4 (RELEASE wins over DECAY).
  - gate held 1 through IDLE → no restart.
